// File: rtl/cassette_recorder.sv
// CoCo cassette recorder: decodes the DAC tone into bytes for a write buffer.
// In: clk, COCO_RESET_N, Q, en, rewind, dac. Out: wr_addr/wr_data/wr_n, full, bit_err, active.
module cassette_recorder #(
  parameter int AW      = 16,
  parameter int MID     = 32,
  parameter int HYST    = 4,
  parameter int MIN_CYC = 200,
  parameter int THRESH  = 560,
  parameter int MAX_CYC = 1100
) (
  input  logic          clk,
  input  logic          COCO_RESET_N,
  input  logic          Q,
  input  logic          en,
  input  logic          rewind,
  input  logic [5:0]    dac,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  output logic          wr_n,
  output logic          full,
  output logic          bit_err,
  output logic          active
);

  localparam logic [6:0]  LV_HI = 7'(MID + HYST);
  localparam logic [6:0]  LV_LO = 7'(MID - HYST);
  localparam logic [10:0] C_MIN = 11'(MIN_CYC);
  localparam logic [10:0] C_THR = 11'(THRESH);
  localparam logic [10:0] C_MAX = 11'(MAX_CYC);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    MEASURE
  } state_t;

  state_t      state, state_nx;
  logic        lv, lv_q, q_q;
  logic [10:0] cnt;
  logic [6:0]  sr;
  logic [2:0]  bitcnt;
  logic        rise, tick;
  logic        take_bit, bad_cyc, drop;
  logic        new_bit, byte_done, do_wr;

  assign rise      = lv & ~lv_q;
  assign tick      = Q & ~q_q;
  assign new_bit   = (cnt < C_THR);
  assign byte_done = take_bit & (bitcnt == 3'd7);
  assign do_wr     = byte_done & ~full;
  assign active    = (state == MEASURE);

  always_ff @(posedge clk or negedge COCO_RESET_N) begin
    if (!COCO_RESET_N) state <= IDLE;
    else               state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    take_bit = 1'b0;
    bad_cyc  = 1'b0;
    drop     = 1'b0;
    if (!en) begin
      state_nx = IDLE;
      drop     = 1'b1;
    end else begin
      unique case (state)
        IDLE:  state_nx = ARMED;
        ARMED: if (rise) state_nx = MEASURE;
        MEASURE: begin
          if (rise) begin
            if (cnt >= C_MIN && cnt <= C_MAX) begin
              take_bit = 1'b1;
            end else begin
              bad_cyc = 1'b1;
              drop    = 1'b1;
            end
          end else if (cnt > C_MAX) begin
            state_nx = ARMED;
            drop     = 1'b1;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge COCO_RESET_N) begin
    if (!COCO_RESET_N) begin
      lv      <= 1'b0;
      lv_q    <= 1'b0;
      q_q     <= 1'b0;
      cnt     <= '0;
      sr      <= '0;
      bitcnt  <= '0;
      bit_err <= 1'b0;
      wr_n    <= 1'b1;
      wr_data <= '0;
      wr_addr <= '0;
      full    <= 1'b0;
    end else begin
      if ({1'b0, dac} >= LV_HI)     lv <= 1'b1;
      else if ({1'b0, dac} < LV_LO) lv <= 1'b0;
      lv_q <= lv;
      q_q  <= Q;
      // a crossing always wins, so timeout and crossing never coincide
      if (rise)                        cnt <= '0;
      else if (tick && cnt != 11'h7FF) cnt <= cnt + 11'd1;
      bit_err <= bad_cyc;
      if (drop) begin
        bitcnt <= '0;
      end else if (take_bit) begin
        sr     <= {new_bit, sr[6:1]};
        bitcnt <= bitcnt + 3'd1;
      end
      wr_n <= ~do_wr;
      if (do_wr) wr_data <= {new_bit, sr};
      // address moves after the strobe; rewind overrides the increment
      if (rewind) begin
        wr_addr <= '0;
        full    <= 1'b0;
      end else if (!wr_n) begin
        if (&wr_addr) full <= 1'b1;
        else          wr_addr <= wr_addr + AW'(1);
      end
    end
  end

endmodule

// File: tb/tb_cassette_recorder.sv
// Directed bench for cassette_recorder: main instance plus a small AW=4 instance.
// Drives DAC cycles of chosen Q-tick length and checks strobes, errors, flags.
`timescale 1ns/1ps
module tb_cassette_recorder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic Q = 1'b0;
  logic en = 1'b0;
  logic en2 = 1'b0;
  logic rewind = 1'b0;
  logic [5:0] dac = 6'd0;
  logic [15:0] wr_addr;
  logic [7:0] wr_data;
  logic wr_n, full, bit_err, active;
  logic [3:0] wr_addr2;
  logic [7:0] wr_data2;
  logic wr_n2, full2, bit_err2, active2;

  int total = 0;
  int bad = 0;
  int strb = 0;
  int errs = 0;
  int strb2 = 0;
  logic [15:0] sa [0:31];
  logic [7:0] sd [0:31];
  logic [3:0] sa2 [0:31];
  logic [7:0] sd2 [0:31];

  always #5 clk = ~clk;

  cassette_recorder dut (
    .clk(clk), .COCO_RESET_N(rst_n), .Q(Q), .en(en),
    .rewind(rewind), .dac(dac), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_n(wr_n), .full(full),
    .bit_err(bit_err), .active(active)
  );

  cassette_recorder #(
    .AW(4), .MIN_CYC(20), .THRESH(56), .MAX_CYC(110)
  ) dut2 (
    .clk(clk), .COCO_RESET_N(rst_n), .Q(Q), .en(en2),
    .rewind(rewind), .dac(dac), .wr_addr(wr_addr2),
    .wr_data(wr_data2), .wr_n(wr_n2), .full(full2),
    .bit_err(bit_err2), .active(active2)
  );

  always @(negedge clk) begin
    if (!wr_n) begin
      if (strb < 32) begin
        sa[strb] <= wr_addr;
        sd[strb] <= wr_data;
      end
      strb <= strb + 1;
    end
    if (bit_err) errs <= errs + 1;
    if (!wr_n2) begin
      if (strb2 < 32) begin
        sa2[strb2] <= wr_addr2;
        sd2[strb2] <= wr_data2;
      end
      strb2 <= strb2 + 1;
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    Q = 1'b1;
    @(negedge clk);
    Q = 1'b0;
    @(negedge clk);
  endtask

  task automatic cyc(input int n);
    dac = 6'd63;
    repeat (2) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      if (i == n / 2) dac = 6'd0;
      tick();
    end
  endtask

  task automatic edge_only();
    dac = 6'd63;
    repeat (4) @(negedge clk);
    dac = 6'd0;
    repeat (3) @(negedge clk);
  endtask

  task automatic prep(input logic e1, input logic e2, input logic rw);
    en = 1'b0;
    en2 = 1'b0;
    rewind = rw;
    dac = 6'd0;
    Q = 1'b0;
    repeat (3) @(negedge clk);
    rewind = 1'b0;
    en = e1;
    en2 = e2;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (wr_addr !== 16'h0) begin bad++; $display("FAIL rst_addr got=%h want=0000", wr_addr); end
    total++; if (wr_data !== 8'h00) begin bad++; $display("FAIL rst_data got=%h want=00", wr_data); end
    total++; if (wr_n !== 1'b1) begin bad++; $display("FAIL rst_wr_n got=%b want=1", wr_n); end
    total++; if ({full, bit_err, active} !== 3'b000) begin bad++; $display("FAIL rst_flags got=%b want=000", {full, bit_err, active}); end
    total++; if ({full2, wr_n2, wr_addr2} !== 6'b010000) begin bad++; $display("FAIL rst_aux got=%b want=010000", {full2, wr_n2, wr_addr2}); end
    rst_n = 1'b1;
    en = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (active !== 1'b0) begin bad++; $display("FAIL armed_inactive got=%b want=0", active); end
  endtask

  task automatic test_zeros();
    int b;
    prep(1'b1, 1'b0, 1'b1);
    b = strb;
    for (int j = 0; j < 8; j++) cyc(746);
    edge_only();
    total++; if (strb - b !== 1) begin bad++; $display("FAIL zeros_count got=%0d want=1", strb - b); end
    total++; if (sd[b] !== 8'h00) begin bad++; $display("FAIL zeros_data got=%h want=00", sd[b]); end
    total++; if (sa[b] !== 16'h0) begin bad++; $display("FAIL zeros_addr got=%h want=0000", sa[b]); end
    total++; if (wr_addr !== 16'h1) begin bad++; $display("FAIL zeros_next got=%h want=0001", wr_addr); end
    total++; if (active !== 1'b1) begin bad++; $display("FAIL zeros_active got=%b want=1", active); end
  endtask

  task automatic test_pattern();
    int b, e;
    logic [7:0] pat [0:1];
    logic [7:0] v;
    pat[0] = 8'h55;
    pat[1] = 8'h3C;
    prep(1'b1, 1'b0, 1'b1);
    b = strb;
    e = errs;
    for (int k = 0; k < 2; k++) begin
      v = pat[k];
      for (int j = 0; j < 8; j++) cyc(v[j] ? 373 : 746);
    end
    edge_only();
    total++; if (strb - b !== 2) begin bad++; $display("FAIL pat_count got=%0d want=2", strb - b); end
    total++; if ({sa[b], sd[b]} !== {16'h0, 8'h55}) begin bad++; $display("FAIL pat_byte0 got=%h/%h want=0000/55", sa[b], sd[b]); end
    total++; if ({sa[b+1], sd[b+1]} !== {16'h1, 8'h3C}) begin bad++; $display("FAIL pat_byte1 got=%h/%h want=0001/3c", sa[b+1], sd[b+1]); end
    total++; if (wr_addr !== 16'h2) begin bad++; $display("FAIL pat_next got=%h want=0002", wr_addr); end
    total++; if (errs - e !== 0) begin bad++; $display("FAIL pat_err got=%0d want=0", errs - e); end
  endtask

  task automatic test_bad_cycle();
    int b, e;
    logic [7:0] v;
    v = 8'hA5;
    prep(1'b1, 1'b0, 1'b1);
    b = strb;
    e = errs;
    for (int j = 0; j < 3; j++) cyc(373);
    cyc(150);
    for (int j = 0; j < 8; j++) cyc(v[j] ? 373 : 746);
    edge_only();
    total++; if (errs - e !== 1) begin bad++; $display("FAIL bad_err got=%0d want=1", errs - e); end
    total++; if (strb - b !== 1) begin bad++; $display("FAIL bad_count got=%0d want=1", strb - b); end
    total++; if (sd[b] !== 8'hA5) begin bad++; $display("FAIL bad_data got=%h want=a5", sd[b]); end
    total++; if (sa[b] !== 16'h0) begin bad++; $display("FAIL bad_addr got=%h want=0000", sa[b]); end
  endtask

  task automatic test_silence();
    int b, e;
    prep(1'b1, 1'b0, 1'b1);
    b = strb;
    e = errs;
    for (int j = 0; j < 5; j++) cyc(373);
    dac = 6'd63;
    repeat (2) @(negedge clk);
    dac = 6'd32;
    repeat (1100) tick();
    total++; if (active !== 1'b1) begin bad++; $display("FAIL sil_1100 got=%b want=1", active); end
    tick();
    total++; if (active !== 1'b0) begin bad++; $display("FAIL sil_1101 got=%b want=0", active); end
    repeat (99) tick();
    dac = 6'd0;
    repeat (2) @(negedge clk);
    for (int j = 0; j < 8; j++) cyc(373);
    total++; if (strb - b !== 0) begin bad++; $display("FAIL sil_early got=%0d want=0", strb - b); end
    edge_only();
    total++; if (strb - b !== 1) begin bad++; $display("FAIL sil_count got=%0d want=1", strb - b); end
    total++; if (sd[b] !== 8'hFF) begin bad++; $display("FAIL sil_data got=%h want=ff", sd[b]); end
    total++; if (errs - e !== 0) begin bad++; $display("FAIL sil_err got=%0d want=0", errs - e); end
  endtask

  task automatic test_full();
    int b;
    prep(1'b0, 1'b1, 1'b1);
    b = strb2;
    for (int j = 0; j < 17 * 8; j++) cyc(37);
    edge_only();
    total++; if (strb2 - b !== 16) begin bad++; $display("FAIL full_count got=%0d want=16", strb2 - b); end
    for (int i = 0; i < 16; i++) begin
      total++; if ({sa2[b+i], sd2[b+i]} !== {4'(i), 8'hFF}) begin bad++; $display("FAIL full_byte%0d got=%h/%h want=%h/ff", i, sa2[b+i], sd2[b+i], 4'(i)); end
    end
    total++; if (full2 !== 1'b1) begin bad++; $display("FAIL full_flag got=%b want=1", full2); end
    total++; if (wr_addr2 !== 4'hF) begin bad++; $display("FAIL full_nowrap got=%h want=f", wr_addr2); end
    rewind = 1'b1;
    repeat (2) @(negedge clk);
    rewind = 1'b0;
    @(negedge clk);
    total++; if ({full2, wr_addr2} !== 5'b0) begin bad++; $display("FAIL full_rewind got=%b/%h want=0/0", full2, wr_addr2); end
  endtask

  task automatic test_reset_mid();
    int b;
    prep(1'b1, 1'b0, 1'b0);
    for (int j = 0; j < 5; j++) cyc(373);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if ({wr_n, active, wr_addr} !== {2'b10, 16'h0}) begin bad++; $display("FAIL mid_rst got=%b/%b/%h want=1/0/0000", wr_n, active, wr_addr); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    b = strb;
    for (int j = 0; j < 8; j++) cyc(373);
    total++; if (strb - b !== 0) begin bad++; $display("FAIL mid_early got=%0d want=0", strb - b); end
    edge_only();
    total++; if (strb - b !== 1) begin bad++; $display("FAIL mid_count got=%0d want=1", strb - b); end
    total++; if ({sa[b], sd[b]} !== {16'h0, 8'hFF}) begin bad++; $display("FAIL mid_byte got=%h/%h want=0000/ff", sa[b], sd[b]); end
    total++; if (wr_addr !== 16'h1) begin bad++; $display("FAIL mid_next got=%h want=0001", wr_addr); end
  endtask

  initial begin
    test_reset();
    test_zeros();
    test_pattern();
    test_bad_cycle();
    test_silence();
    test_full();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cassette_recorder.md
CASSETTE_RECORDER -- requirements
Module: cassette_recorder

Interface
REQ-001 Parameter AW, 16, width of the buffer address counter (64 KiB buffer).
REQ-002 Parameter MID, 32, DAC midpoint used for the zero-crossing comparator.
REQ-003 Parameter HYST, 4, comparator hysteresis in DAC codes.
REQ-004 Parameter MIN_CYC, 200, minimum valid full-cycle length in Q ticks.
REQ-005 Parameter THRESH, 560, full-cycle length below which a cycle is decoded as bit 1; at or above it, as bit 0.
REQ-006 Parameter MAX_CYC, 1100, maximum valid full-cycle length in Q ticks.
REQ-007 clk  in  1  system clock; all logic is rising-edge clocked; one clock only.
REQ-008 COCO_RESET_N  in  1  asynchronous, active-low reset.
REQ-009 Q  in  1  CoCo Q clock level, synchronous to clk; each rising edge is one Q tick.
REQ-010 en  in  1  cassette motor relay; 1 = recording enabled.
REQ-011 rewind  in  1  level; while 1, forces the write address to 0 and clears full.
REQ-012 dac  in  6  CoCo 6-bit sound DAC value (cassette output waveform).
REQ-013 wr_addr  out  AW  buffer write address.
REQ-014 wr_data  out  8  byte to be written.
REQ-015 wr_n  out  1  active-low write strobe, one clk wide.
REQ-016 full  out  1  sticky flag: the buffer is exhausted.
REQ-017 bit_err  out  1  one-clk pulse on an out-of-range cycle length.
REQ-018 active  out  1  1 while the FSM is in MEASURE.

Function
REQ-019 Comparator level lv: set to 1 when dac >= MID+HYST; cleared to 0 when dac < MID-HYST; otherwise holds its value.
REQ-020 Rising crossing: lv 0->1 between consecutive clks.
REQ-021 Q tick: Q registered once; a tick is Q=1 while the registered Q=0.
REQ-022 Period counter: 11 bits, counts Q ticks, saturates at 2047, and is cleared on every rising crossing.
REQ-023 FSM states: IDLE, ARMED, MEASURE.
REQ-024 IDLE -> ARMED when en=1.
REQ-025 ARMED -> MEASURE on a rising crossing; the period counter clears and no bit is decoded.
REQ-026 MEASURE, rising crossing with MIN_CYC <= count <= MAX_CYC: decode one bit (count < THRESH -> 1, else 0).
REQ-027 Decoded bits shift into the shift register LSB-first (shift right, new bit enters bit 7), and bitcnt increments.
REQ-028 MEASURE, rising crossing with count outside [MIN_CYC, MAX_CYC]: discard the partial byte (bitcnt=0), pulse bit_err for one clk, and remain in MEASURE.
REQ-029 MEASURE, count reaches MAX_CYC+1 with no crossing (silence): go to ARMED and discard the partial byte; no bit_err.
REQ-030 Any state, en=0: go to IDLE next clk and discard the partial byte; wr_addr is retained.
REQ-031 Byte complete (8th bit decoded):
  - next clk: wr_n=0 for exactly one clk;
  - wr_data = assembled byte;
  - wr_addr = write address, stable during the strobe.
REQ-032 wr_addr increments on the clk after the strobe; wr_data holds its value until the next byte.
REQ-033 Write address 2^AW-1 written: set full; wr_addr does not wrap.
REQ-034 While full=1, completed bytes are dropped (no strobe) and decoding continues.
REQ-035 rewind=1: wr_addr=0 and full=0 next clk.
REQ-036 rewind during a strobe: the write completes at the old address, then wr_addr=0 (rewind beats the increment).
REQ-037 A rising crossing and a silence timeout never coincide, because the crossing clears the counter first.
REQ-038 A crossing in the same clk as en falling is ignored; en has priority.

Reset
REQ-039 COCO_RESET_N=0 asynchronously forces:
  - FSM=IDLE;
  - wr_addr=0, wr_data=0x00, wr_n=1;
  - full=0, bit_err=0, active=0;
  - lv=0, period counter=0, shift register=0, bitcnt=0.
REQ-040 Reset deassertion mid-stream restarts from IDLE; no partial byte or strobe survives.

Verification
REQ-041 en=1, 1200 Hz square wave (746 Q ticks/cycle) for 1 arming + 8 cycles -> one strobe: wr_data=0x00 at wr_addr=0, then wr_addr=1.
REQ-042 Cycles encoding 0x55 (alternating 373/746 ticks, LSB first), then 0x3C -> strobes at addr 0 and 1 with data 0x55, 0x3C.
REQ-043 Three valid bits, one 150-tick cycle, then 8 bits of 0xA5 -> bit_err pulse once; single strobe with 0xA5.
REQ-044 Five bits, then 1200 ticks of flat DAC=MID, then arming + 0xFF -> active drops after 1101 ticks; byte 0xFF written; no bit_err.
REQ-045 AW=4, 17 bytes -> 16 strobes at addr 0..15, full=1, 17th dropped; rewind pulse -> wr_addr=0, full=0.
REQ-046 COCO_RESET_N low after 4 bits, then 8 bits -> no strobe until 8 bits after the re-arm crossing; wr_addr starts at 0.
